// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT datapath and its PSD accumulator.
package fft_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BITREV_DW = 2 * DATA_W;

    // One complex sample; Re sits in the upper half of the stream word.
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic                 valid;
        logic [BITREV_DW-1:0] data;
    } strm_t;

    // Frame position of a beat within one averaging window.
    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACC   = 2'd1,
        ST_LAST  = 2'd2
    } psd_state_e;

    // |x|^2 as an unsigned word; the largest result is 2^(2*DATA_W-1), so it never wraps.
    function automatic logic [BITREV_DW-1:0] psd_pwr(input complex_t c);
        logic signed [BITREV_DW-1:0] re_x;
        logic signed [BITREV_DW-1:0] im_x;
        re_x = {{DATA_W{c.re[DATA_W-1]}}, c.re};
        im_x = {{DATA_W{c.im[DATA_W-1]}}, c.im};
        return re_x * re_x + im_x * im_x;
    endfunction

endpackage

// File: rtl/fft_psd_mem.sv
// Per-bin accumulator storage: synchronous write, asynchronous read, no reset.
module fft_psd_mem #(
    parameter int unsigned LOGN  = 10,
    parameter int unsigned ACC_W = 34
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [LOGN-1:0]  waddr_i,
    input  logic [ACC_W-1:0] wdata_i,
    input  logic [LOGN-1:0]  raddr_i,
    output logic [ACC_W-1:0] rdata_o
);

    localparam int unsigned N = 1 << LOGN;

    logic [ACC_W-1:0] mem_q [N];

    // Write port; contents are always overwritten by the first frame, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_psd_accum.sv
// Power-spectral-density accumulator: squares each {Re,Im} beat and averages
// 2^LOG_AVG frames per bin, emitting one averaged spectrum per window.
// Optional peak tracker enabled by defining FFT_PSD_PEAK_EN.
module fft_psd_accum
    import fft_pkg::*;
#(
    parameter int unsigned LOGN    = 10,
    parameter int unsigned LOG_AVG = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  strm_t                psd_in_i,
    output logic                 ready_o,
    input  logic                 clear_i,
    output strm_t                psd_out_o,
    input  logic                 ready_i,
    output logic                 last_o
`ifdef FFT_PSD_PEAK_EN
    ,
    output logic                 peak_vld_o,
    output logic [LOGN-1:0]      peak_bin_o,
    output logic [BITREV_DW-1:0] peak_pwr_o
`endif
);

    localparam int unsigned ACC_W = BITREV_DW + LOG_AVG;
    localparam int unsigned FRM_W = (LOG_AVG > 0) ? LOG_AVG : 1;
    localparam logic [LOGN-1:0]  BIN_MAX     = LOGN'((1 << LOGN) - 1);
    localparam logic [FRM_W-1:0] FRM_MAX     = FRM_W'((1 << LOG_AVG) - 1);
    localparam logic [FRM_W-1:0] FRM_PRELAST = FRM_W'((1 << LOG_AVG) - 2);
    // Without averaging every frame is the last one.
    localparam psd_state_e ST_INIT = (LOG_AVG == 0) ? ST_LAST : ST_FIRST;

    logic                 adv;
    logic                 accept;
    logic [LOGN-1:0]      bin_cnt_q, bin_cnt_d;
    logic [FRM_W-1:0]     frm_cnt_q, frm_cnt_d;
    psd_state_e           state_q, state_d;

    logic                 s1_vld_q, s1_vld_d;
    logic [BITREV_DW-1:0] s1_pwr_q, s1_pwr_d;
    logic [LOGN-1:0]      s1_bin_q, s1_bin_d;
    psd_state_e           s1_st_q, s1_st_d;

    logic                 out_vld_q, out_vld_d;
    logic [BITREV_DW-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;

    logic [ACC_W-1:0]     acc_rd;
    logic [ACC_W-1:0]     acc_sum;
    logic [ACC_W-1:0]     acc_wdata;
    logic                 acc_we;
    logic                 s2_fire;
    logic                 s2_emit;
    logic [BITREV_DW-1:0] out_pwr;

    // Both stages move together; the input stalls only when the output is held.
    assign adv     = !out_vld_q || ready_i;
    assign ready_o = adv;
    assign accept  = psd_in_i.valid && adv && !clear_i;

    // Bin/frame counters and frame-position FSM on the input side.
    always_comb begin
        bin_cnt_d = bin_cnt_q;
        frm_cnt_d = frm_cnt_q;
        state_d   = state_q;
        if (clear_i) begin
            bin_cnt_d = '0;
            frm_cnt_d = '0;
            state_d   = ST_INIT;
        end else if (accept) begin
            bin_cnt_d = bin_cnt_q + 1'b1;
            if (bin_cnt_q == BIN_MAX) begin
                frm_cnt_d = (frm_cnt_q == FRM_MAX) ? '0 : frm_cnt_q + 1'b1;
                case (state_q)
                    ST_FIRST: state_d = (LOG_AVG == 1) ? ST_LAST : ST_ACC;
                    ST_ACC:   state_d = (frm_cnt_q == FRM_PRELAST) ? ST_LAST : ST_ACC;
                    ST_LAST:  state_d = ST_INIT;
                    default:  state_d = ST_INIT;
                endcase
            end
        end
    end

    // Stage 1: square the accepted beat and tag it with its bin and frame position.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_pwr_d = s1_pwr_q;
        s1_bin_d = s1_bin_q;
        s1_st_d  = s1_st_q;
        if (clear_i) begin
            s1_vld_d = 1'b0;
        end else if (adv) begin
            s1_vld_d = accept;
            s1_pwr_d = psd_pwr(complex_t'(psd_in_i.data));
            s1_bin_d = bin_cnt_q;
            s1_st_d  = state_q;
        end
    end

    assign acc_sum   = acc_rd + ACC_W'(s1_pwr_q);
    assign s2_fire   = adv && s1_vld_q && !clear_i;
    assign s2_emit   = s2_fire && (s1_st_q == ST_LAST);
    assign acc_we    = s2_fire && (s1_st_q != ST_LAST);
    assign acc_wdata = (s1_st_q == ST_FIRST) ? ACC_W'(s1_pwr_q) : acc_sum;
    assign out_pwr   = (LOG_AVG == 0) ? s1_pwr_q : BITREV_DW'(acc_sum >> LOG_AVG);

    // Stage 2: only last-frame beats reach the output register.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (clear_i) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end else if (adv) begin
            out_vld_d  = s2_emit;
            out_last_d = s2_emit && (s1_bin_q == BIN_MAX);
            if (s2_emit) begin
                out_data_d = out_pwr;
            end
        end
    end

    // Pipeline, counter and FSM state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            state_q    <= ST_INIT;
            s1_vld_q   <= 1'b0;
            s1_pwr_q   <= '0;
            s1_bin_q   <= '0;
            s1_st_q    <= ST_INIT;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            bin_cnt_q  <= bin_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            state_q    <= state_d;
            s1_vld_q   <= s1_vld_d;
            s1_pwr_q   <= s1_pwr_d;
            s1_bin_q   <= s1_bin_d;
            s1_st_q    <= s1_st_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    fft_psd_mem #(
        .LOGN  (LOGN),
        .ACC_W (ACC_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (acc_we),
        .waddr_i (s1_bin_q),
        .wdata_i (acc_wdata),
        .raddr_i (s1_bin_q),
        .rdata_o (acc_rd)
    );

    assign psd_out_o.valid = out_vld_q;
    assign psd_out_o.data  = out_data_q;
    assign last_o          = out_last_q;

`ifdef FFT_PSD_PEAK_EN
    logic [BITREV_DW-1:0] run_pwr_q, run_pwr_d;
    logic [LOGN-1:0]      run_bin_q, run_bin_d;
    logic                 peak_vld_q, peak_vld_d;
    logic [LOGN-1:0]      peak_bin_q, peak_bin_d;
    logic [BITREV_DW-1:0] peak_pwr_q, peak_pwr_d;

    // Running max over the emitted frame (strict compare keeps the lower bin on ties);
    // published when the last beat leaves.
    always_comb begin
        run_pwr_d  = run_pwr_q;
        run_bin_d  = run_bin_q;
        peak_vld_d = 1'b0;
        peak_bin_d = peak_bin_q;
        peak_pwr_d = peak_pwr_q;
        if (out_vld_q && ready_i && out_last_q) begin
            peak_vld_d = 1'b1;
            peak_bin_d = run_bin_q;
            peak_pwr_d = run_pwr_q;
        end
        if (s2_emit && ((s1_bin_q == '0) || (out_pwr > run_pwr_q))) begin
            run_pwr_d = out_pwr;
            run_bin_d = s1_bin_q;
        end
    end

    // Peak tracker state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_pwr_q  <= '0;
            run_bin_q  <= '0;
            peak_vld_q <= 1'b0;
            peak_bin_q <= '0;
            peak_pwr_q <= '0;
        end else begin
            run_pwr_q  <= run_pwr_d;
            run_bin_q  <= run_bin_d;
            peak_vld_q <= peak_vld_d;
            peak_bin_q <= peak_bin_d;
            peak_pwr_q <= peak_pwr_d;
        end
    end

    assign peak_vld_o = peak_vld_q;
    assign peak_bin_o = peak_bin_q;
    assign peak_pwr_o = peak_pwr_q;
`endif

endmodule

// File: tb/tb_fft_psd_accum.sv
// Directed bench for fft_psd_accum with N=8 bins, 4-frame averaging.
module tb_fft_psd_accum;
    import fft_pkg::*;

    localparam int unsigned LOGN    = 3;
    localparam int unsigned LOG_AVG = 2;
    localparam int          N       = 8;
    localparam int          AVG     = 4;

    logic  clk_i   = 1'b0;
    logic  rst_ni  = 1'b0;
    logic  clear_i = 1'b0;
    logic  ready_i = 1'b1;
    logic  ready_o;
    logic  last_o;
    strm_t psd_in_i;
    strm_t psd_out_o;
`ifdef FFT_PSD_PEAK_EN
    logic                 peak_vld_o;
    logic [LOGN-1:0]      peak_bin_o;
    logic [BITREV_DW-1:0] peak_pwr_o;
    int                   peak_cnt = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];

    fft_psd_accum #(
        .LOGN    (LOGN),
        .LOG_AVG (LOG_AVG)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .psd_in_i  (psd_in_i),
        .ready_o   (ready_o),
        .clear_i   (clear_i),
        .psd_out_o (psd_out_o),
        .ready_i   (ready_i),
        .last_o    (last_o)
`ifdef FFT_PSD_PEAK_EN
        ,
        .peak_vld_o (peak_vld_o),
        .peak_bin_o (peak_bin_o),
        .peak_pwr_o (peak_pwr_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Record every output beat that the next rising edge will accept.
    always @(negedge clk_i) begin
        if (rst_ni && psd_out_o.valid && ready_i) begin
            got_data.push_back(psd_out_o.data);
            got_last.push_back(last_o);
        end
`ifdef FFT_PSD_PEAK_EN
        if (rst_ni && peak_vld_o) peak_cnt++;
`endif
    end

    task automatic send_beat(input int re, input int im);
        int t;
        t = 0;
        psd_in_i.valid = 1'b1;
        psd_in_i.data  = {16'(re), 16'(im)};
        forever begin
            @(negedge clk_i);
            if (ready_o) break;
            t++;
            if (t > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_beat_timeout: ready_o stuck at %0b, required 1", ready_o);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        psd_in_i.valid = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge clk_i);
        #1;
    endtask

    task automatic flush_queue();
        got_data.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_cmp++;
        if (psd_out_o.valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b, required 0", psd_out_o.valid);
        end
        n_cmp++;
        if (psd_out_o.data !== 32'd0) begin
            n_err++; $display("FAIL reset_data: got %0h, required 0", psd_out_o.data);
        end
        n_cmp++;
        if (last_o !== 1'b0) begin
            n_err++; $display("FAIL reset_last: got %0b, required 0", last_o);
        end
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %0b, required 1", ready_o);
        end
`ifdef FFT_PSD_PEAK_EN
        n_cmp++;
        if (peak_vld_o !== 1'b0 || peak_bin_o !== '0 || peak_pwr_o !== '0) begin
            n_err++;
            $display("FAIL reset_peak: got %0b/%0d/%0d, required 0/0/0",
                     peak_vld_o, peak_bin_o, peak_pwr_o);
        end
`endif
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_constant();
        flush_queue();
        for (int f = 0; f < AVG - 1; f++)
            for (int b = 0; b < N; b++) send_beat(3, 4);
        drain();
        n_cmp++;
        if (got_data.size() != 0) begin
            n_err++; $display("FAIL const_early_out: got %0d beats, required 0", got_data.size());
        end
        for (int b = 0; b < N; b++) send_beat(3, 4);
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++; $display("FAIL const_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 32'd25 || got_last[i] !== (i == N - 1)) begin
                n_err++;
                $display("FAIL const_beat%0d: got %0d last %0b, required 25 last %0b",
                         i, got_data[i], got_last[i], (i == N - 1));
            end
        end
    endtask

    task automatic test_averaging();
        logic [31:0] exp;
        flush_queue();
        for (int f = 0; f < AVG; f++)
            for (int b = 0; b < N; b++) begin
                if (b == 0)      send_beat(f + 1, 0);
                else if (b == 1) send_beat(f, 1);
                else             send_beat(b, f);
            end
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++; $display("FAIL avg_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            // bin0: (1+4+9+16)/4=7; bin1: (1+2+5+10)/4=4; others: (4b^2+14)/4=b^2+3
            if (i == 0)      exp = 32'd7;
            else if (i == 1) exp = 32'd4;
            else             exp = 32'(i * i + 3);
            n_cmp++;
            if (got_data[i] !== exp) begin
                n_err++; $display("FAIL avg_bin%0d: got %0d, required %0d", i, got_data[i], exp);
            end
        end
    endtask

    task automatic test_extremes();
        flush_queue();
        for (int f = 0; f < AVG; f++)
            for (int b = 0; b < N; b++) send_beat(-32768, -32768);
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++; $display("FAIL max_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 32'h8000_0000) begin
                n_err++; $display("FAIL max_bin%0d: got %0h, required 80000000", i, got_data[i]);
            end
        end
        flush_queue();
        for (int f = 0; f < AVG; f++)
            for (int b = 0; b < N; b++) send_beat(0, 0);
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++; $display("FAIL zero_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 32'd0) begin
                n_err++; $display("FAIL zero_bin%0d: got %0h, required 0", i, got_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        flush_queue();
        fork
            begin
                for (int f = 0; f < AVG; f++)
                    for (int b = 0; b < N; b++) send_beat(b, 0);
            end
            begin
                logic [31:0] held_data;
                logic        held_vld;
                logic        held_last;
                int          t;
                t = 0;
                while (got_data.size() < 3 && t < 2000) begin
                    @(negedge clk_i);
                    t++;
                end
                n_cmp++;
                if (got_data.size() < 3) begin
                    n_err++; $display("FAIL bp_wait: got %0d beats, required 3", got_data.size());
                end
                @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                @(negedge clk_i);
                held_data = psd_out_o.data;
                held_vld  = psd_out_o.valid;
                held_last = last_o;
                n_cmp++;
                if (held_vld !== 1'b1) begin
                    n_err++; $display("FAIL bp_valid: got %0b, required 1", held_vld);
                end
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk_i);
                    n_cmp++;
                    if (ready_o !== 1'b0 || psd_out_o.valid !== held_vld ||
                        psd_out_o.data !== held_data || last_o !== held_last) begin
                        n_err++;
                        $display("FAIL bp_hold%0d: got rdy %0b vld %0b data %0d, required 0 %0b %0d",
                                 c, ready_o, psd_out_o.valid, psd_out_o.data, held_vld, held_data);
                    end
                end
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++; $display("FAIL bp_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 32'(i * i) || got_last[i] !== (i == N - 1)) begin
                n_err++;
                $display("FAIL bp_beat%0d: got %0d last %0b, required %0d last %0b",
                         i, got_data[i], got_last[i], i * i, (i == N - 1));
            end
        end
    endtask

    // Abort in bin 5 of frame 2 via reset (use_clear=0) or clear_i (use_clear=1).
    task automatic test_abort(input bit use_clear);
        flush_queue();
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < N; b++) begin
                if (f == 2 && b == 5) break;
                send_beat(7, 0);
            end
        if (use_clear) begin
            psd_in_i.valid = 1'b1;
            psd_in_i.data  = {16'd7, 16'd0};
            clear_i        = 1'b1;
            @(negedge clk_i);
            n_cmp++;
            if (ready_o !== 1'b1) begin
                n_err++; $display("FAIL clear_ready: got %0b, required 1", ready_o);
            end
            @(posedge clk_i);
            #1;
            clear_i        = 1'b0;
            psd_in_i.valid = 1'b0;
        end else begin
            rst_ni = 1'b0;
            @(negedge clk_i);
            #1;
            rst_ni = 1'b1;
            @(posedge clk_i);
            #1;
        end
        for (int f = 0; f < AVG; f++)
            for (int b = 0; b < N; b++) begin
                if (use_clear) send_beat(1, 2);
                else           send_beat(3, 4);
            end
        drain();
        n_cmp++;
        if (got_data.size() != N) begin
            n_err++;
            $display("FAIL abort%0d_count: got %0d beats, required %0d",
                     use_clear, got_data.size(), N);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== (use_clear ? 32'd5 : 32'd25)) begin
                n_err++;
                $display("FAIL abort%0d_bin%0d: got %0d, required %0d",
                         use_clear, i, got_data[i], use_clear ? 5 : 25);
            end
        end
    endtask

`ifdef FFT_PSD_PEAK_EN
    task automatic test_peak();
        flush_queue();
        peak_cnt = 0;
        for (int f = 0; f < AVG; f++)
            for (int b = 0; b < N; b++) send_beat((b == 2 || b == 6) ? 10 : 1, 0);
        drain();
        n_cmp++;
        if (peak_cnt != 1) begin
            n_err++; $display("FAIL peak_pulses: got %0d, required 1", peak_cnt);
        end
        n_cmp++;
        if (peak_bin_o !== 3'd2) begin
            n_err++; $display("FAIL peak_bin: got %0d, required 2", peak_bin_o);
        end
        n_cmp++;
        if (peak_pwr_o !== 32'd100) begin
            n_err++; $display("FAIL peak_pwr: got %0d, required 100", peak_pwr_o);
        end
    endtask
`endif

    initial begin
        psd_in_i.valid = 1'b0;
        psd_in_i.data  = '0;
        test_reset();
        test_constant();
        test_averaging();
        test_extremes();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
`ifdef FFT_PSD_PEAK_EN
        test_peak();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
